// File: rtl/seq_mem_pkg.sv
// seq_mem_pkg: types and constants shared by the colour-sequence memory, its arbiter and the game FSM.
package seq_mem_pkg;

    localparam int SIZE_ADDRESS = 5;
    localparam int COD_COLOR    = 2;
    localparam int SIZE_MEM     = 2 ** SIZE_ADDRESS;

    typedef enum logic [COD_COLOR-1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } color_t;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_ACCESS = 2'd1,
        A_ACK    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/seq_mem_arbiter.sv
// seq_mem_arbiter: serialises two requesters onto the single-port colour-sequence memory,
// inserting read-latency wait states and returning data with a one-cycle ack.
module seq_mem_arbiter
    import seq_mem_pkg::*;
#(
    parameter int ADDR_W = SIZE_ADDRESS,
    parameter int DATA_W = COD_COLOR,
    parameter int RD_LAT = 2,
    parameter int RR_EN  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              wr,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    localparam int CW = $clog2(RD_LAT) + 1;

    arb_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              rd_q, rd_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        ack_q, ack_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              win;

    // last_q doubles as the owner of the transaction in flight
    assign win = (req0 && req1) ? ((RR_EN != 0) ? !last_q : 1'b0) : req1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        rd_d      = rd_q;
        gnt_d     = gnt_q;
        ack_d     = ack_q;
        wr_d      = wr_q;
        busy_d    = busy_q;
        address_d = address_q;
        data_in_d = data_in_q;
        rdata_d   = rdata_q;
        case (state_q)
            A_IDLE: if (req0 || req1) begin
                address_d = win ? addr1 : addr0;
                data_in_d = win ? wdata1 : wdata0;
                wr_d      = win ? we1 : we0;
                rd_d      = !wr_d;
                gnt_d     = win ? 2'b10 : 2'b01;
                busy_d    = 1'b1;
                cnt_d     = wr_d ? '0 : CW'(RD_LAT - 1);
                last_d    = win;
                state_d   = A_ACCESS;
            end
            A_ACCESS: begin
                wr_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rdata_d = rd_q ? data_out : rdata_q;
                    ack_d   = last_q ? 2'b10 : 2'b01;
                    state_d = A_ACK;
                end
            end
            A_ACK: begin
                ack_d   = 2'b00;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
                state_d = A_IDLE;
            end
            default: state_d = A_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= A_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            rd_q      <= 1'b0;
            gnt_q     <= '0;
            ack_q     <= '0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            address_q <= '0;
            data_in_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rd_q      <= rd_d;
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            address_q <= address_d;
            data_in_q <= data_in_d;
            rdata_q   <= rdata_d;
        end
    end

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign ack0    = ack_q[0];
    assign ack1    = ack_q[1];
    assign wr      = wr_q;
    assign busy    = busy_q;
    assign address = address_q;
    assign data_in = data_in_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_seq_mem_arbiter.sv
// tb_seq_mem_arbiter: three arbiter instances (RR lat 2, fixed-priority lat 2, RR lat 4),
// each on its own behavioural pipelined memory, checked against a transaction-level model.
module tb_seq_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ld = 1'b0;
    logic [4:0] ld_a = '0;
    logic [1:0] ld_d = '0;
    int         cyc = 0;

    logic [1:0] req [3];
    logic [1:0] we [3];
    logic [4:0] addr [3][2];
    logic [1:0] wd [3][2];

    wire [1:0] gnt [3];
    wire [1:0] ack [3];
    wire [1:0] rdata [3];
    wire [1:0] data_in [3];
    wire [1:0] data_out [3];
    wire       busy [3];
    wire       wr [3];
    wire [4:0] address [3];

    logic [1:0] mm [3][32];
    logic [1:0] rd_m [3];
    int         last_m [3];
    int         iss [3];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_i
        localparam int LAT = (g == 2) ? 4 : 2;
        logic [1:0] mem [32];
        logic [1:0] pipe [LAT-1];
        seq_mem_arbiter #(.RD_LAT(LAT), .RR_EN((g == 1) ? 0 : 1)) dut (
            .clock(clock), .reset(reset),
            .req0(req[g][0]), .we0(we[g][0]), .addr0(addr[g][0]), .wdata0(wd[g][0]),
            .req1(req[g][1]), .we1(we[g][1]), .addr1(addr[g][1]), .wdata1(wd[g][1]),
            .gnt0(gnt[g][0]), .gnt1(gnt[g][1]), .ack0(ack[g][0]), .ack1(ack[g][1]),
            .rdata(rdata[g]), .busy(busy[g]), .wr(wr[g]), .address(address[g]),
            .data_in(data_in[g]), .data_out(data_out[g])
        );
        always @(posedge clock) begin
            if (ld) mem[ld_a] <= ld_d;
            else if (wr[g]) mem[address[g]] <= data_in[g];
            pipe[0] <= mem[address[g]];
            for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
        end
        assign data_out[g] = pipe[LAT-2];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic setreq(input int i, input int p, input logic w, input logic [4:0] a, input logic [1:0] d);
        req[i][p] = 1'b1;
        we[i][p] = w;
        addr[i][p] = a;
        wd[i][p] = d;
    endtask

    task automatic rnd(input int i, input int p);
        setreq(i, p, 1'($urandom_range(0, 1)), 5'($urandom), 2'($urandom));
    endtask

    // Runs one transaction from an idle negedge; mode 0 drops the winner's req at ack,
    // 1 keeps it held, 2 drops it and raises the other port if that one is idle.
    task automatic txn(input int i, input int lat, input int mode);
        int w;
        int n;
        logic wexp;
        logic [4:0] aexp;
        logic [1:0] dexp;
        logic [1:0] rexp;
        w = (req[i] == 2'b11) ? ((i != 1) ? ((last_m[i] == 0) ? 1 : 0) : 0) : (req[i][1] ? 1 : 0);
        wexp = we[i][w];
        aexp = addr[i][w];
        dexp = wd[i][w];
        @(posedge clock);
        last_m[i] = w;
        @(negedge clock);
        iss[i] = cyc;
        chk("gnt_issue", gnt[i], 32'(1 << w));
        chk("busy_issue", busy[i], 1);
        chk("address", address[i], aexp);
        chk("wr_issue", wr[i], wexp);
        if (wexp) chk("data_in", data_in[i], dexp);
        n = 0;
        while (ack[i] == 2'b00 && n < 12) begin
            @(negedge clock);
            n++;
            chk("wr_once", wr[i], 0);
            chk("gnt_hold", gnt[i], 32'(1 << w));
        end
        chk("latency", n, wexp ? 1 : lat);
        chk("ack_port", ack[i], 32'(1 << w));
        rexp = wexp ? rd_m[i] : mm[i][aexp];
        chk("rdata", rdata[i], rexp);
        rd_m[i] = rexp;
        if (wexp) mm[i][aexp] = dexp;
        if (mode != 1) req[i][w] = 1'b0;
        if (mode == 2 && !req[i][1-w]) rnd(i, 1 - w);
        @(negedge clock);
        chk("ack_end", ack[i], 0);
        chk("gnt_end", gnt[i], 0);
        chk("busy_end", busy[i], 0);
    endtask

    task automatic chk_zero(input int i);
        chk("rst_busy", busy[i], 0);
        chk("rst_gnt", gnt[i], 0);
        chk("rst_ack", ack[i], 0);
        chk("rst_wr", wr[i], 0);
        chk("rst_address", address[i], 0);
        chk("rst_data_in", data_in[i], 0);
        chk("rst_rdata", rdata[i], 0);
    endtask

    initial begin
        int p;
        for (int i = 0; i < 3; i++) begin
            req[i] = '0;
            we[i] = '0;
            last_m[i] = 1;
            rd_m[i] = '0;
            for (int q = 0; q < 2; q++) begin
                addr[i][q] = '0;
                wd[i][q] = '0;
            end
        end
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) chk_zero(i);
        reset = 1'b0;
        ld = 1'b1;
        for (int a = 0; a < 32; a++) begin
            ld_a = 5'(a);
            ld_d = (a == 5) ? 2'd3 : (a == 0) ? 2'd1 : 2'($urandom);
            for (int i = 0; i < 3; i++) mm[i][a] = ld_d;
            @(negedge clock);
        end
        ld = 1'b0;

        setreq(0, 0, 1'b0, 5'd5, 2'd0);
        txn(0, 2, 0);
        chk("read5", rdata[0], 3);

        setreq(0, 1, 1'b1, 5'd31, 2'd2);
        txn(0, 2, 0);
        setreq(0, 0, 1'b0, 5'd31, 2'd0);
        txn(0, 2, 0);
        chk("read31", rdata[0], 2);

        setreq(0, 0, 1'b0, 5'd3, 2'd0);
        setreq(0, 1, 1'b0, 5'd17, 2'd0);
        txn(0, 2, 1);
        p = iss[0];
        for (int k = 0; k < 5; k++) begin
            txn(0, 2, 1);
            chk("rr_period", iss[0] - p, 4);
            p = iss[0];
        end
        req[0] = 2'b00;

        setreq(1, 0, 1'b0, 5'd8, 2'd0);
        setreq(1, 1, 1'b0, 5'd9, 2'd0);
        for (int k = 0; k < 4; k++) txn(1, 2, 1);
        req[1] = 2'b00;

        setreq(2, 0, 1'b0, 5'd0, 2'd0);
        setreq(2, 1, 1'b0, 5'd12, 2'd0);
        txn(2, 4, 1);
        p = iss[2];
        for (int k = 0; k < 3; k++) begin
            txn(2, 4, 1);
            chk("lat4_period", iss[2] - p, 6);
            p = iss[2];
        end
        req[2] = 2'b00;

        setreq(0, 0, 1'b0, 5'd9, 2'd0);
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1 chk_zero(0);
        @(negedge clock);
        chk_zero(0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            last_m[i] = 1;
            rd_m[i] = '0;
        end
        txn(0, 2, 0);

        setreq(0, 0, 1'b0, 5'd4, 2'd0);
        txn(0, 2, 2);
        chk("handoff_req", req[0], 2'b10);
        txn(0, 2, 0);
        chk("handoff_idle", gnt[0], 0);

        for (int k = 0; k < 40; k++) begin
            for (int q = 0; q < 2; q++) if (!req[0][q] && $urandom_range(0, 1) == 1) rnd(0, q);
            if (req[0] == 2'b00) rnd(0, int'($urandom_range(0, 1)));
            txn(0, 2, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
